// File: rtl/csr_sequencer_pkg.sv
// csr_sequencer_pkg: shared CSR index, mstatus bit, op and sequencer state definitions
package csr_sequencer_pkg;
  localparam int XLEN = 64;
  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] MSTATUS_IDX = 5'd0;
  localparam logic [IDX_W-1:0] MTVEC_IDX = 5'd3;
  localparam logic [IDX_W-1:0] MEPC_IDX = 5'd6;
  localparam logic [IDX_W-1:0] MCAUSE_IDX = 5'd8;
  localparam logic [IDX_W-1:0] MTVAL_IDX = 5'd10;
  localparam int MIE_BIT = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO = 11;
  localparam int MPP_HI = 12;
  typedef enum logic [1:0] {OP_ILL = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} csr_op_t;
  typedef enum logic [2:0] {IDLE, INST, T_EPC, T_CAUSE, T_TVAL, T_STAT, R_EPC, R_STAT} seq_state_t;
endpackage

// File: rtl/csr_wdata_merge.sv
// csr_wdata_merge: computes masked CSRRW/RS/RC write data and write enable
module csr_wdata_merge
  import csr_sequencer_pkg::*;
(
  input  csr_op_t         op,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src,
  input  logic [XLEN-1:0] mask,
  output logic [XLEN-1:0] wdata,
  output logic            we
);
  logic [XLEN-1:0] src_e, new_val;
  always_comb begin
    src_e = (op == OP_ILL) ? '0 : src;
    new_val = (op == OP_RW) ? src_e : (op == OP_RC) ? (old_val & ~src_e) : (old_val | src_e);
    wdata = (old_val & ~mask) | (new_val & mask);
    we = (op == OP_RW) || (src_e != '0);
  end
endmodule

// File: rtl/csr_sequencer.sv
// csr_sequencer: serialises CSR instructions and trap/MRET sequences onto the CSR array
module csr_sequencer
  import csr_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_valid,
  input  logic [1:0]       inst_op,
  input  logic [IDX_W-1:0] inst_idx,
  input  logic [XLEN-1:0]  inst_mask,
  input  logic [XLEN-1:0]  inst_src,
  output logic             inst_ready,
  output logic             inst_done,
  output logic [XLEN-1:0]  inst_rdata,
  input  logic             trap_valid,
  input  logic             trap_kind,
  input  logic [XLEN-1:0]  trap_pc,
  input  logic [XLEN-1:0]  trap_cause,
  input  logic [XLEN-1:0]  trap_tval,
  input  logic [1:0]       trap_prv,
  output logic             trap_ready,
  output logic             trap_done,
  output logic [XLEN-1:0]  trap_target,
  output logic [1:0]       ret_prv,
  output logic [IDX_W-1:0] csr_raddr,
  input  logic [XLEN-1:0]  csr_rdata,
  output logic             csr_we,
  output logic [IDX_W-1:0] csr_waddr,
  output logic [XLEN-1:0]  csr_wdata,
  output logic             busy
);
  seq_state_t state_q, state_d;
  csr_op_t op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0] mask_q, mask_d, src_q, src_d, pc_q, pc_d, cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d, mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [1:0] prv_q, prv_d;
  logic [XLEN-1:0] m_wdata;
  logic m_we;

  csr_wdata_merge u_merge (
    .op(op_q), .old_val(csr_rdata), .src(src_q), .mask(mask_q), .wdata(m_wdata), .we(m_we)
  );

  assign busy = state_q != IDLE;

  always_comb begin
    state_d = state_q;
    op_d = op_q;
    idx_d = idx_q;
    mask_d = mask_q;
    src_d = src_q;
    pc_d = pc_q;
    cause_d = cause_q;
    tval_d = tval_q;
    prv_d = prv_q;
    mtvec_d = mtvec_q;
    mepc_d = mepc_q;
    inst_ready = 1'b0;
    trap_ready = 1'b0;
    inst_done = 1'b0;
    trap_done = 1'b0;
    inst_rdata = '0;
    trap_target = '0;
    ret_prv = 2'b00;
    csr_raddr = '0;
    csr_waddr = '0;
    csr_we = 1'b0;
    csr_wdata = '0;
    case (state_q)
      IDLE: begin
        trap_ready = trap_valid;
        inst_ready = inst_valid & ~trap_valid;
        if (trap_valid) begin
          pc_d = trap_pc;
          cause_d = trap_cause;
          tval_d = trap_tval;
          prv_d = trap_prv;
          state_d = trap_kind ? R_EPC : T_EPC;
        end else if (inst_valid) begin
          op_d = csr_op_t'(inst_op);
          idx_d = inst_idx;
          mask_d = inst_mask;
          src_d = inst_src;
          state_d = INST;
        end
      end
      INST: begin
        csr_raddr = idx_q;
        csr_waddr = idx_q;
        csr_we = m_we;
        csr_wdata = m_wdata;
        inst_done = 1'b1;
        inst_rdata = csr_rdata;
        state_d = IDLE;
      end
      T_EPC: begin
        csr_waddr = MEPC_IDX;
        csr_we = 1'b1;
        csr_wdata = pc_q & ~64'h1;
        csr_raddr = MTVEC_IDX;
        mtvec_d = csr_rdata;
        state_d = T_CAUSE;
      end
      T_CAUSE: begin
        csr_waddr = MCAUSE_IDX;
        csr_we = 1'b1;
        csr_wdata = cause_q;
        state_d = T_TVAL;
      end
      T_TVAL: begin
        csr_waddr = MTVAL_IDX;
        csr_we = 1'b1;
        csr_wdata = tval_q;
        state_d = T_STAT;
      end
      T_STAT: begin
        csr_raddr = MSTATUS_IDX;
        csr_waddr = MSTATUS_IDX;
        csr_we = 1'b1;
        csr_wdata = csr_rdata;
        csr_wdata[MPIE_BIT] = csr_rdata[MIE_BIT];
        csr_wdata[MIE_BIT] = 1'b0;
        csr_wdata[MPP_HI:MPP_LO] = prv_q;
        trap_done = 1'b1;
        // vectored mode only offsets interrupts, never synchronous exceptions
        trap_target = (mtvec_q & ~64'h3) +
                      ((mtvec_q[0] & cause_q[XLEN-1]) ? {{(XLEN-8){1'b0}}, cause_q[5:0], 2'b00} : '0);
        state_d = IDLE;
      end
      R_EPC: begin
        csr_raddr = MEPC_IDX;
        mepc_d = csr_rdata;
        state_d = R_STAT;
      end
      R_STAT: begin
        csr_raddr = MSTATUS_IDX;
        csr_waddr = MSTATUS_IDX;
        csr_we = 1'b1;
        csr_wdata = csr_rdata;
        csr_wdata[MIE_BIT] = csr_rdata[MPIE_BIT];
        csr_wdata[MPIE_BIT] = 1'b1;
        csr_wdata[MPP_HI:MPP_LO] = 2'b00;
        ret_prv = csr_rdata[MPP_HI:MPP_LO];
        trap_target = mepc_q;
        trap_done = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      op_q <= OP_ILL;
      idx_q <= '0;
      mask_q <= '0;
      src_q <= '0;
      pc_q <= '0;
      cause_q <= '0;
      tval_q <= '0;
      prv_q <= 2'b00;
      mtvec_q <= '0;
      mepc_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      idx_q <= idx_d;
      mask_q <= mask_d;
      src_q <= src_d;
      pc_q <= pc_d;
      cause_q <= cause_d;
      tval_q <= tval_d;
      prv_q <= prv_d;
      mtvec_q <= mtvec_d;
      mepc_q <= mepc_d;
    end
  end
endmodule

// File: tb/tb_csr_sequencer.sv
// tb_csr_sequencer: randomized scoreboard bench with a CSR array model and transaction-level reference
module tb_csr_sequencer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic inst_valid = 1'b0;
  logic [1:0] inst_op = 2'b00;
  logic [4:0] inst_idx = '0;
  logic [63:0] inst_mask = '0, inst_src = '0;
  logic inst_ready, inst_done;
  logic [63:0] inst_rdata;
  logic trap_valid = 1'b0, trap_kind = 1'b0;
  logic [63:0] trap_pc = '0, trap_cause = '0, trap_tval = '0;
  logic [1:0] trap_prv = 2'b00;
  logic trap_ready, trap_done;
  logic [63:0] trap_target;
  logic [1:0] ret_prv;
  logic [4:0] csr_raddr, csr_waddr;
  logic [63:0] csr_rdata, csr_wdata;
  logic csr_we, busy;

  typedef struct {bit is_trap; logic [63:0] val; logic [1:0] prv; bit chk_prv; int lat;} exp_t;
  typedef struct {logic [4:0] a; logic [63:0] d;} wr_t;
  exp_t exp_q[$];
  wr_t exp_wr[$];
  exp_t e;
  wr_t w;

  logic [63:0] mem [32] = '{default: 64'h0};
  logic [63:0] ref_mem [32] = '{default: 64'h0};
  logic poke_en = 1'b0;
  logic [4:0] poke_idx = '0;
  logic [63:0] poke_val = '0;
  int vectors = 0, miscompares = 0, cyc = 0, acc_cyc = 0;

  csr_sequencer dut (
    .clk(clk), .resetn(resetn),
    .inst_valid(inst_valid), .inst_op(inst_op), .inst_idx(inst_idx), .inst_mask(inst_mask),
    .inst_src(inst_src), .inst_ready(inst_ready), .inst_done(inst_done), .inst_rdata(inst_rdata),
    .trap_valid(trap_valid), .trap_kind(trap_kind), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .trap_tval(trap_tval), .trap_prv(trap_prv), .trap_ready(trap_ready), .trap_done(trap_done),
    .trap_target(trap_target), .ret_prv(ret_prv),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_we(csr_we), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign csr_rdata = mem[csr_raddr];
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (csr_we) mem[csr_waddr] <= csr_wdata;
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (resetn) begin
      if (csr_we) begin
        if (exp_wr.size() == 0) chk("unexpected_write_addr", {59'b0, csr_waddr}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          w = exp_wr.pop_front();
          chk("csr_waddr", {59'b0, csr_waddr}, {59'b0, w.a});
          chk("csr_wdata", csr_wdata, w.d);
        end
      end
      if (inst_done || trap_done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 64'h1, 64'h0);
        else begin
          e = exp_q.pop_front();
          chk("done_kind", {63'b0, trap_done}, {63'b0, e.is_trap});
          chk("done_latency", 64'(cyc - acc_cyc), 64'(e.lat));
          if (e.is_trap) chk("trap_target", trap_target, e.val);
          else chk("inst_rdata", inst_rdata, e.val);
          if (e.chk_prv) chk("ret_prv", {62'b0, ret_prv}, {62'b0, e.prv});
        end
      end
      if ((inst_valid && inst_ready) || (trap_valid && trap_ready)) acc_cyc = cyc;
    end
  end

  function automatic void model_inst(logic [1:0] op, logic [4:0] idx, logic [63:0] mask, logic [63:0] src);
    logic [63:0] old, s, nv, wv;
    old = ref_mem[idx];
    s = (op == 2'd0) ? 64'd0 : src;
    case (op)
      2'd1: nv = s;
      2'd3: nv = old & ~s;
      default: nv = old | s;
    endcase
    wv = old ^ ((old ^ nv) & mask);
    exp_q.push_back('{0, old, 2'b00, 0, 1});
    if (op == 2'd1 || s != 0) begin
      exp_wr.push_back('{idx, wv});
      ref_mem[idx] = wv;
    end
  endfunction

  function automatic void model_trap(logic [63:0] pc, logic [63:0] cause, logic [63:0] tval, logic [1:0] prv);
    logic [63:0] tv, tgt, old, ms;
    tv = ref_mem[3];
    tgt = tv - (tv % 4);
    if (tv % 2 == 1 && cause[63]) tgt = tgt + (cause % 64) * 4;
    old = ref_mem[0];
    ms = (old & ~64'h1888) | (((old >> 3) & 1) << 7) | (64'(prv) << 11);
    exp_wr.push_back('{5'd6, pc - (pc % 2)});
    exp_wr.push_back('{5'd8, cause});
    exp_wr.push_back('{5'd10, tval});
    exp_wr.push_back('{5'd0, ms});
    ref_mem[6] = pc - (pc % 2);
    ref_mem[8] = cause;
    ref_mem[10] = tval;
    ref_mem[0] = ms;
    exp_q.push_back('{1, tgt, 2'b00, 0, 4});
  endfunction

  function automatic void model_mret();
    logic [63:0] old, ms;
    old = ref_mem[0];
    ms = (old & ~64'h1888) | (((old >> 7) & 1) << 3) | 64'h80;
    exp_q.push_back('{1, ref_mem[6], 2'((old >> 11) & 3), 1, 2});
    exp_wr.push_back('{5'd0, ms});
    ref_mem[0] = ms;
  endfunction

  task automatic poke(input logic [4:0] idx, input logic [63:0] val);
    @(posedge clk) #1;
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    ref_mem[idx] = val;
    @(posedge clk) #1;
    poke_en = 1'b0;
  endtask

  task automatic wait_ready(input bit is_trap);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_trap ? trap_ready : inst_ready) begin
        @(posedge clk) #1;
        return;
      end
    end
    chk("ready_timeout", 64'h0, 64'h1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 64'h0, 64'h1);
  endtask

  task automatic do_inst(input logic [1:0] op, input logic [4:0] idx, input logic [63:0] mask, input logic [63:0] src);
    model_inst(op, idx, mask, src);
    @(posedge clk) #1;
    inst_valid = 1'b1; inst_op = op; inst_idx = idx; inst_mask = mask; inst_src = src;
    wait_ready(0);
    inst_valid = 1'b0;
    wait_idle();
  endtask

  task automatic drive_trap(input logic kind, input logic [63:0] pc, input logic [63:0] cause,
                            input logic [63:0] tval, input logic [1:0] prv);
    trap_valid = 1'b1; trap_kind = kind; trap_pc = pc; trap_cause = cause; trap_tval = tval; trap_prv = prv;
  endtask

  task automatic do_trap(input logic kind, input logic [63:0] pc, input logic [63:0] cause,
                         input logic [63:0] tval, input logic [1:0] prv);
    if (kind) model_mret(); else model_trap(pc, cause, tval, prv);
    @(posedge clk) #1;
    drive_trap(kind, pc, cause, tval, prv);
    wait_ready(1);
    trap_valid = 1'b0;
    wait_idle();
  endtask

  task automatic do_both(input logic [63:0] pc, input logic [63:0] cause, input logic [1:0] prv,
                         input logic [1:0] op, input logic [4:0] idx, input logic [63:0] mask, input logic [63:0] src);
    bit seen;
    model_trap(pc, cause, 64'h55, prv);
    model_inst(op, idx, mask, src);
    @(posedge clk) #1;
    drive_trap(1'b0, pc, cause, 64'h55, prv);
    inst_valid = 1'b1; inst_op = op; inst_idx = idx; inst_mask = mask; inst_src = src;
    @(negedge clk);
    chk("both_trap_ready", {63'b0, trap_ready}, 64'h1);
    chk("both_inst_ready", {63'b0, inst_ready}, 64'h0);
    @(posedge clk) #1;
    trap_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (trap_done) begin
        seen = 1;
        chk("ready_in_done_cycle", {63'b0, inst_ready}, 64'h0);
      end
    end
    if (!seen) chk("trap_done_timeout", 64'h0, 64'h1);
    @(negedge clk);
    chk("ready_after_done", {63'b0, inst_ready}, 64'h1);
    @(posedge clk) #1;
    inst_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'h0);
    chk("rst_csr_we", {63'b0, csr_we}, 64'h0);
    chk("rst_inst_rdata", inst_rdata, 64'h0);
    chk("rst_trap_target", trap_target, 64'h0);
    chk("rst_done", {62'b0, inst_done, trap_done}, 64'h0);
    @(posedge clk) #1 resetn = 1'b1;

    poke(5'd5, 64'h0);
    do_inst(2'b01, 5'd5, '1, 64'hDEAD_BEEF);
    poke(5'd0, 64'h88);
    do_inst(2'b11, 5'd0, '1, 64'h0);
    do_inst(2'b10, 5'd0, 64'h2, 64'h2);
    poke(5'd3, 64'h8000_0100);
    poke(5'd0, 64'h8);
    do_both(64'h8000_0004, 64'h2, 2'd3, 2'b10, 5'd5, '1, 64'h100);
    poke(5'd3, 64'h8000_0101);
    do_trap(1'b0, 64'h8000_0040, 64'h8000_0000_0000_0007, 64'h0, 2'd0);
    poke(5'd6, 64'h8000_0200);
    poke(5'd0, 64'h1880);
    do_trap(1'b1, 64'h0, 64'h0, 64'h0, 2'd0);
    do_inst(2'b00, 5'd7, '1, 64'h1234);

    poke(5'd8, 64'h1234);
    pc = 64'h8000_0ABD;
    exp_wr.push_back('{5'd6, 64'h8000_0ABC});
    ref_mem[6] = 64'h8000_0ABC;
    @(posedge clk) #1;
    drive_trap(1'b0, pc, 64'h5, 64'h9, 2'd1);
    wait_ready(1);
    trap_valid = 1'b0;
    @(posedge clk) #1;
    chk("abort_we_before", {63'b0, csr_we}, 64'h1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_we_async", {63'b0, csr_we}, 64'h0);
    chk("abort_busy", {63'b0, busy}, 64'h0);
    @(posedge clk);
    @(posedge clk) #1 resetn = 1'b1;
    chk("abort_mepc", mem[6], ref_mem[6]);
    chk("abort_mcause", mem[8], 64'h1234);
    do_inst(2'b10, 5'd8, '1, 64'h1);

    for (int n = 0; n < 200; n++) begin
      int r;
      logic [63:0] m, s, c;
      r = $urandom_range(0, 11);
      m = ($urandom_range(0, 2) == 0) ? '1 : {$urandom, $urandom};
      s = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
      c = {1'($urandom_range(0, 1)), 57'($urandom), 6'($urandom)};
      if (r == 10) poke(5'd3, {$urandom, $urandom});
      else if (r == 11) poke(5'd0, {$urandom, $urandom});
      else if (r < 6) do_inst(2'($urandom), 5'($urandom), m, s);
      else if (r < 8) do_trap(1'b0, {$urandom, $urandom}, c, {$urandom, $urandom}, 2'($urandom));
      else if (r == 8) do_trap(1'b1, 64'h0, 64'h0, 64'h0, 2'd0);
      else do_both({$urandom, $urandom}, c, 2'($urandom), 2'($urandom), 5'($urandom), m, s);
    end

    repeat (3) @(negedge clk);
    chk("exp_q_empty", 64'(exp_q.size()), 64'h0);
    chk("exp_wr_empty", 64'(exp_wr.size()), 64'h0);
    for (int i = 0; i < 32; i++) chk($sformatf("mem_%0d", i), mem[i], ref_mem[i]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
